// File: rtl/arm_controller.sv
// Arm/disarm state machine for a flight controller: stick-gesture arming with hold time,
// throttle gating and PWM loss-of-signal failsafe. Optional macro ARM_SWITCH_SAFETY_EN adds an arm switch interlock.
module arm_controller #(
    parameter int unsigned VALUE_WIDTH         = 8,
    parameter int unsigned THROTTLE_LOW_MAX    = 10,
    parameter int unsigned YAW_HIGH_MIN        = 240,
    parameter int unsigned YAW_LOW_MAX         = 15,
    parameter int unsigned HOLD_TIME_US        = 1000000,
    parameter int unsigned FAILSAFE_TIMEOUT_US = 100000,
    parameter int unsigned SWITCH_ARM_MIN      = 128
) (
    input  logic                   us_clk,
    input  logic                   reset,
    input  logic [VALUE_WIDTH-1:0] throttle_val,
    input  logic [VALUE_WIDTH-1:0] yaw_val,
    input  logic [VALUE_WIDTH-1:0] swa_swb_val,
    input  logic                   throttle_pwm,
    output logic                   armed,
    output logic                   failsafe,
    output logic [2:0]             state,
    output logic [VALUE_WIDTH-1:0] throttle_out
);

    localparam int unsigned HOLD_W = $clog2(HOLD_TIME_US + 1);
    localparam int unsigned LOSS_W = $clog2(FAILSAFE_TIMEOUT_US + 1);

    localparam logic [VALUE_WIDTH-1:0] THR_LOW  = VALUE_WIDTH'(THROTTLE_LOW_MAX);
    localparam logic [VALUE_WIDTH-1:0] YAW_HIGH = VALUE_WIDTH'(YAW_HIGH_MIN);
    localparam logic [VALUE_WIDTH-1:0] YAW_LOW  = VALUE_WIDTH'(YAW_LOW_MAX);
    localparam logic [HOLD_W-1:0]      HOLD_END = HOLD_W'(HOLD_TIME_US - 1);
    localparam logic [LOSS_W-1:0]      LOSS_MAX = LOSS_W'(FAILSAFE_TIMEOUT_US);

    typedef enum logic [2:0] {
        ST_DISARMED  = 3'd0,
        ST_ARMING    = 3'd1,
        ST_ARMED     = 3'd2,
        ST_DISARMING = 3'd3,
        ST_FAILSAFE  = 3'd4
    } state_t;

    state_t             cur_state;
    state_t             next_state;
    logic [1:0]         sync;
    logic               sync_prev;
    logic [LOSS_W-1:0]  loss_cnt;
    logic [HOLD_W-1:0]  hold_cnt;

    logic pwm_rise;
    logic signal_lost;
    logic throttle_low;
    logic arm_gesture;
    logic disarm_gesture;
    logic hold_done;

    assign pwm_rise       = sync[1] & ~sync_prev;
    assign signal_lost    = (loss_cnt == LOSS_MAX);
    assign throttle_low   = (throttle_val <= THR_LOW);
    assign disarm_gesture = throttle_low && (yaw_val <= YAW_LOW);
    assign hold_done      = (hold_cnt == HOLD_END);

`ifdef ARM_SWITCH_SAFETY_EN
    logic switch_on;
    assign switch_on   = (swa_swb_val >= VALUE_WIDTH'(SWITCH_ARM_MIN));
    assign arm_gesture = throttle_low && (yaw_val >= YAW_HIGH) && switch_on;
`else
    logic unused_switch;
    assign unused_switch = ^swa_swb_val;
    assign arm_gesture   = throttle_low && (yaw_val >= YAW_HIGH);
`endif

    // Later assignments override earlier ones: failsafe outranks the switch interlock,
    // which outranks the gesture transitions.
    always_comb begin
        // NOTE: default first so every path assigns next_state and no latch is inferred.
        next_state = cur_state;
        case (cur_state)
            ST_DISARMED:  if (arm_gesture) next_state = ST_ARMING;
            ST_ARMING: begin
                if (!arm_gesture)   next_state = ST_DISARMED;
                else if (hold_done) next_state = ST_ARMED;
            end
            ST_ARMED:     if (disarm_gesture) next_state = ST_DISARMING;
            ST_DISARMING: begin
                if (!disarm_gesture) next_state = ST_ARMED;
                else if (hold_done)  next_state = ST_DISARMED;
            end
            ST_FAILSAFE:  if (throttle_low) next_state = ST_DISARMED;
            default:      next_state = ST_DISARMED;
        endcase
`ifdef ARM_SWITCH_SAFETY_EN
        if (!switch_on && (cur_state == ST_ARMING || cur_state == ST_ARMED ||
                           cur_state == ST_DISARMING))
            next_state = ST_DISARMED;
`endif
        if (signal_lost) next_state = ST_FAILSAFE;
    end

    always_ff @(posedge us_clk) begin
        if (reset) begin
            sync         <= '0;
            sync_prev    <= 1'b0;
            loss_cnt     <= '0;
            hold_cnt     <= '0;
            cur_state    <= ST_DISARMED;
            armed        <= 1'b0;
            failsafe     <= 1'b0;
            throttle_out <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values; the
            // synchronizer chain relies on this to delay by exactly one stage per flop.
            sync      <= {sync[0], throttle_pwm};
            sync_prev <= sync[1];

            if (pwm_rise)          loss_cnt <= '0;
            else if (!signal_lost) loss_cnt <= loss_cnt + 1'b1;

            if (next_state != cur_state)
                hold_cnt <= '0;
            else if (cur_state == ST_ARMING || cur_state == ST_DISARMING)
                hold_cnt <= hold_cnt + 1'b1;
            else
                hold_cnt <= '0;

            cur_state <= next_state;
            armed     <= (next_state == ST_ARMED) || (next_state == ST_DISARMING);
            failsafe  <= (next_state == ST_FAILSAFE);
            throttle_out <= ((next_state == ST_ARMED) || (next_state == ST_DISARMING))
                            ? throttle_val : '0;
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_arm_controller.sv
// Self-checking bench for arm_controller: directed scenarios plus randomized stick/PWM
// segments, all compared every cycle against a cycle-count-based reference model.
module tb_arm_controller;

    localparam int HOLD = 20;
    localparam int TO   = 30;

    logic       us_clk = 1'b0;
    logic       reset  = 1'b1;
    logic [7:0] throttle_val = 8'd0;
    logic [7:0] yaw_val      = 8'd128;
    logic [7:0] swa_swb_val  = 8'd200;
    logic       throttle_pwm = 1'b0;
    logic       armed;
    logic       failsafe;
    logic [2:0] state;
    logic [7:0] throttle_out;

    always #5 us_clk = ~us_clk;

    arm_controller #(
        .VALUE_WIDTH(8), .THROTTLE_LOW_MAX(10), .YAW_HIGH_MIN(240), .YAW_LOW_MAX(15),
        .HOLD_TIME_US(HOLD), .FAILSAFE_TIMEOUT_US(TO), .SWITCH_ARM_MIN(128)
    ) dut (
        .us_clk(us_clk), .reset(reset), .throttle_val(throttle_val), .yaw_val(yaw_val),
        .swa_swb_val(swa_swb_val), .throttle_pwm(throttle_pwm), .armed(armed),
        .failsafe(failsafe), .state(state), .throttle_out(throttle_out)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: states as plain codes, timing as elapsed cycle counts.
    int n          = 0;   // clock edges seen
    int m_state    = 0;
    int entered    = 0;   // edge at which m_state was entered
    int last_clear = 0;   // edge at which the last PWM edge restarted the loss timer
    int m_thr      = 0;
    bit hist[$]    = '{1'b0, 1'b0, 1'b0};  // raw PWM samples of the last three edges
    bit pwm_on     = 1'b1;
    int phase      = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s @edge %0d: observed %0d expected %0d", tag, n, obs, exp);
        end
    endtask

    task automatic model_step();
        bit clr, lost, thr_low, arm_g, dis_g;
        int held, nx;
        if (reset) begin
            m_state = 0; entered = n; last_clear = n; m_thr = 0;
            hist = '{1'b0, 1'b0, 1'b0};
            return;
        end
        clr     = hist[1] && !hist[0];
        lost    = ((n - 1) - last_clear) >= TO;
        held    = (n - 1) - entered;
        thr_low = throttle_val <= 10;
        arm_g   = thr_low && yaw_val >= 240;
`ifdef ARM_SWITCH_SAFETY_EN
        arm_g   = arm_g && swa_swb_val >= 128;
`endif
        dis_g   = thr_low && yaw_val <= 15;
        case (m_state)
            0: nx = arm_g ? 1 : 0;
            1: nx = !arm_g ? 0 : (held == HOLD - 1 ? 2 : 1);
            2: nx = dis_g ? 3 : 2;
            3: nx = !dis_g ? 2 : (held == HOLD - 1 ? 0 : 3);
            default: nx = thr_low ? 0 : 4;
        endcase
`ifdef ARM_SWITCH_SAFETY_EN
        if (swa_swb_val < 128 && m_state >= 1 && m_state <= 3) nx = 0;
`endif
        if (lost) nx = 4;
        if (nx != m_state) entered = n;
        m_state = nx;
        if (clr) last_clear = n;
        hist.push_back(throttle_pwm);
        void'(hist.pop_front());
        m_thr = (nx == 2 || nx == 3) ? int'(throttle_val) : 0;
    endtask

    task automatic tick();
        throttle_pwm = pwm_on ? ((phase % 8) < 4) : 1'b0;
        phase++;
        @(posedge us_clk);
        n++;
        model_step();
        #1;
        check("state", state, m_state);
        check("armed", armed, (m_state == 2 || m_state == 3));
        check("failsafe", failsafe, (m_state == 4));
        check("throttle_out", throttle_out, m_thr);
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    initial begin
        int thr_sel, yaw_sel, sw_sel, len;

        // Reset state
        ticks(3);
        check("reset_state", state, 0);
        check("reset_armed", armed, 0);
        check("reset_thr_out", throttle_out, 0);
        reset = 1'b0;
        ticks(5);

        // Full arm gesture: ARMING for exactly HOLD cycles, then ARMED
        throttle_val = 8'd0; yaw_val = 8'd250;
        for (int i = 0; i < HOLD; i++) begin
            tick();
            check("arming_hold", state, 1);
        end
        tick();
        check("armed_after_hold", state, 2);
        check("armed_flag", armed, 1);

        // Throttle passes through while ARMED
        throttle_val = 8'd100; yaw_val = 8'd128;
        tick();
        check("thr_pass", throttle_out, 100);

        // Full disarm gesture
        throttle_val = 8'd0; yaw_val = 8'd0;
        ticks(HOLD + 1);
        check("disarmed", state, 0);
        check("disarmed_thr", throttle_out, 0);

        // Aborted gesture, then a fresh full-length one
        yaw_val = 8'd250;
        ticks(HOLD / 2);
        yaw_val = 8'd128;
        tick();
        check("abort_state", state, 0);
        yaw_val = 8'd250;
        for (int i = 0; i < HOLD; i++) begin
            tick();
            check("rearm_hold", state, 1);
        end
        tick();
        check("rearmed", state, 2);

        // Loss of PWM while ARMED
        yaw_val = 8'd128; throttle_val = 8'd60;
        pwm_on = 1'b0;
        ticks(TO + 5);
        check("fs_flag", failsafe, 1);
        check("fs_state", state, 4);
        check("fs_thr", throttle_out, 0);
        pwm_on = 1'b1; throttle_val = 8'd50;
        ticks(20);
        check("fs_hold_thr_high", state, 4);
        throttle_val = 8'd0;
        tick();
        check("fs_exit", state, 0);

        // Reset pulse while ARMED
        yaw_val = 8'd255;
        ticks(HOLD + 1);
        check("pre_reset_armed", state, 2);
        yaw_val = 8'd128; throttle_val = 8'd80;
        tick();
        reset = 1'b1;
        tick();
        check("reset_pulse_state", state, 0);
        check("reset_pulse_armed", armed, 0);
        check("reset_pulse_thr", throttle_out, 0);
        reset = 1'b0;
        tick();
        check("post_reset_state", state, 0);

`ifdef ARM_SWITCH_SAFETY_EN
        // Switch interlock: no arming with switch off, instant disarm when it drops
        throttle_val = 8'd0; yaw_val = 8'd250; swa_swb_val = 8'd0;
        ticks(2 * HOLD);
        check("sw_off_no_arm", state, 0);
        swa_swb_val = 8'd200;
        ticks(HOLD + 1);
        check("sw_on_armed", state, 2);
        yaw_val = 8'd128; swa_swb_val = 8'd0;
        tick();
        check("sw_drop_disarm", state, 0);
        swa_swb_val = 8'd200;
`endif

        // Randomized segments around the thresholds
        for (int s = 0; s < 300; s++) begin
            thr_sel = int'($urandom_range(0, 5));
            case (thr_sel)
                0: throttle_val = 8'd0;
                1: throttle_val = 8'd10;
                2: throttle_val = 8'd11;
                3: throttle_val = 8'd5;
                4: throttle_val = 8'($urandom);
                default: throttle_val = 8'd100;
            endcase
            yaw_sel = int'($urandom_range(0, 6));
            case (yaw_sel)
                0: yaw_val = 8'd0;
                1: yaw_val = 8'd15;
                2: yaw_val = 8'd16;
                3: yaw_val = 8'd239;
                4: yaw_val = 8'd240;
                5: yaw_val = 8'd255;
                default: yaw_val = 8'($urandom);
            endcase
            sw_sel = int'($urandom_range(0, 5));
            case (sw_sel)
                0: swa_swb_val = 8'd0;
                1: swa_swb_val = 8'd127;
                2: swa_swb_val = 8'd128;
                default: swa_swb_val = 8'd255;
            endcase
            pwm_on = ($urandom_range(0, 5) != 0);
            reset  = ($urandom_range(0, 39) == 0);
            len    = int'($urandom_range(1, HOLD + 15));
            if (reset) len = 1;
            ticks(len);
            reset = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/arm_controller.md
ARM_CONTROLLER -- requirements
Module: arm_controller

Interface
REQ-001 Parameter VALUE_WIDTH, default 8: width of the receiver value inputs and throttle_out.
REQ-002 Parameter THROTTLE_LOW_MAX, default 10: throttle_val at or below this counts as "throttle low".
REQ-003 Parameter YAW_HIGH_MIN, default 240: yaw_val at or above this counts as the arm stick position.
REQ-004 Parameter YAW_LOW_MAX, default 15: yaw_val at or below this counts as the disarm stick position.
REQ-005 Parameter HOLD_TIME_US, default 1000000: number of us_clk cycles a gesture must be held continuously.
REQ-006 Parameter FAILSAFE_TIMEOUT_US, default 100000: number of us_clk cycles without a throttle_pwm rising edge before declaring signal loss.
REQ-007 Parameter SWITCH_ARM_MIN, default 128: swa_swb_val at or above this counts as the arm switch on (used only under the REQ-029 macro).
REQ-008 us_clk  input  1  1 MHz clock, the only clock; all logic is rising-edge.
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 throttle_val, yaw_val, swa_swb_val  input  VALUE_WIDTH each  decoded stick and switch values from the receiver block.
REQ-011 throttle_pwm  input  1  raw, asynchronous throttle PWM from the hardware receiver, used for loss-of-signal detection.
REQ-012 armed  output  1  high in ARMED and DISARMING.
REQ-013 failsafe  output  1  high in FAILSAFE.
REQ-014 state  output  3  encoding: DISARMED=0, ARMING=1, ARMED=2, DISARMING=3, FAILSAFE=4.
REQ-015 throttle_out  output  VALUE_WIDTH  gated throttle for the motor mixer.

Function
REQ-016 throttle_pwm shall pass through a 2-flop synchronizer; a rising edge is sync[1]=1 while the previous sample=0.
REQ-017 The loss counter shall clear on each detected edge, otherwise increment, and saturate at FAILSAFE_TIMEOUT_US; signal_lost = (counter == FAILSAFE_TIMEOUT_US).
REQ-018 Arm gesture = throttle low AND yaw_val >= YAW_HIGH_MIN; disarm gesture = throttle low AND yaw_val <= YAW_LOW_MAX.
REQ-019 The hold counter shall clear on every state transition and increment by one each cycle spent in ARMING or DISARMING.
REQ-020 DISARMED: arm gesture -> ARMING; otherwise stay.
REQ-021 ARMING: gesture dropped -> DISARMED; hold counter == HOLD_TIME_US-1 with gesture still present -> ARMED.
REQ-022 ARMED: disarm gesture -> DISARMING; otherwise stay.
REQ-023 DISARMING: gesture dropped -> ARMED; hold counter == HOLD_TIME_US-1 with gesture still present -> DISARMED.
REQ-024 signal_lost asserted in any state shall force FAILSAFE on the next edge, taking priority over every other transition.
REQ-025 FAILSAFE -> DISARMED only when signal_lost is low AND throttle is low; FAILSAFE shall never go directly to ARMED or ARMING.
REQ-026 throttle_out shall be registered: throttle_val one cycle later while the next state is ARMED or DISARMING, otherwise 0.
REQ-027 All comparisons shall be unsigned; counters shall be wide enough to hold their maximum parameter value without wrap.

Reset
REQ-028 On reset: state=DISARMED, armed=0, failsafe=0, throttle_out=0, hold counter=0, loss counter=0, synchronizer flops=0; reset asserted mid-gesture or while ARMED shall abandon it and return to DISARMED.

Configuration
REQ-029 Macro ARM_SWITCH_SAFETY_EN: when defined, the arm gesture additionally requires swa_swb_val >= SWITCH_ARM_MIN, and switch off in ARMING, ARMED or DISARMING forces DISARMED on the next edge (below failsafe in priority); when undefined, swa_swb_val is ignored.

Verification
REQ-030 Throttle=0, yaw=250, edges every 20000 cycles, hold 1000000 cycles -> state 1 for 1000000 cycles, then state=2, armed=1.
REQ-031 Arm gesture held 500000 cycles then yaw=128 -> state returns to 0; a re-applied gesture needs a full 1000000 cycles.
REQ-032 ARMED, throttle_val=100 -> throttle_out=100 one cycle later; throttle=0, yaw=0 held 1000000 cycles -> state=0, throttle_out=0.
REQ-033 ARMED, throttle_pwm held low for 100000 cycles -> failsafe=1, state=4, throttle_out=0; edges resume with throttle=50 -> stays 4; throttle=0 -> state=0.
REQ-034 ARM_SWITCH_SAFETY_EN defined, swa_swb=0, arm gesture held 2000000 cycles -> state stays 0; in ARMED, swa_swb drops to 0 -> state=0 next cycle.
REQ-035 ARMED, reset pulsed for one cycle -> all outputs 0, state=0 on the following cycle.
